sampletest_stream: RTL and testbench

- Parametrised successor to the rasterizer's per-fragment sample test.
- Each transaction carries one triangle, its colour and SAMPS sample locations. The block evaluates edge equations per sample and emits a per-sample hit mask, hit coordinates and colour.
- Adds valid/ready flow control with a stallable PIPE_DEPTH pipeline and a runtime cull mode (back-face or two-sided).
- Sits between the sample iterator and the z-buffer/hash stage.

---
 rtl/sampletest_stream.sv | 190 +++++++++++++++++++
 tb/tb_sampletest_stream.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sampletest_stream.sv
// Streaming per-sample triangle edge test with a stallable valid/ready pipeline.
// Optional hit counter when SAMPLETEST_STATS_EN is defined.
module sampletest_stream #(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int VERTS      = 3,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int SAMPS      = 4,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [VERTS*AXIS*SIGFIG-1:0]  tri_R16S,
    input  logic [COLORS*SIGFIG-1:0]      color_R16U,
    input  logic [2*SAMPS*SIGFIG-1:0]     sample_R16S,
    input  logic [SAMPS-1:0]              validSamp_R16H,
    input  logic                          cull_mode_R16H,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [AXIS*SAMPS*SIGFIG-1:0]  hit_R18S,
    output logic [COLORS*SIGFIG-1:0]      color_R18U,
    output logic [SAMPS-1:0]              hit_valid_R18H,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef SAMPLETEST_STATS_EN
    ,
    input  logic                          stat_clr,
    output logic [31:0]                   stat_hits
`endif
);

    localparam int CW = SIGFIG + 1;
    localparam int DW = 2 * SIGFIG + 4;
    localparam int HW = AXIS * SAMPS * SIGFIG;
    localparam int OW = COLORS * SIGFIG;

    if (VERTS != 3 || AXIS < 3 || RADIX >= SIGFIG || PIPE_DEPTH < 1) begin : g_bad
        $error("sampletest_stream: unsupported parameters");
    end

    logic [HW-1:0]    w_hit;
    logic [SAMPS-1:0] w_mask;
    logic             w_unused;

    // Vertex z of v1/v2 is never needed; tri[0] axes >= 2 feed the hit location.
    assign w_unused = ^tri_R16S;

    for (genvar s = 0; s < SAMPS; s++) begin : g_samp
        logic [SIGFIG-1:0]    w_sx;
        logic [SIGFIG-1:0]    w_sy;
        logic signed [CW-1:0] w_vx [VERTS];
        logic signed [CW-1:0] w_vy [VERTS];
        logic signed [DW-1:0] w_d  [VERTS];
        logic [VERTS-1:0]     w_neg;
        logic [VERTS-1:0]     w_zero;
        logic                 w_in_neg;
        logic                 w_in_pos;

        assign w_sx = sample_R16S[s*SIGFIG +: SIGFIG];
        assign w_sy = sample_R16S[(SAMPS+s)*SIGFIG +: SIGFIG];

        for (genvar i = 0; i < VERTS; i++) begin : g_vert
            localparam int J = (i + 1) % VERTS;
            logic [SIGFIG-1:0] w_tx;
            logic [SIGFIG-1:0] w_ty;

            assign w_tx = tri_R16S[(i*AXIS+0)*SIGFIG +: SIGFIG];
            assign w_ty = tri_R16S[(i*AXIS+1)*SIGFIG +: SIGFIG];
            assign w_vx[i] = $signed({w_tx[SIGFIG-1], w_tx})
                           - $signed({w_sx[SIGFIG-1], w_sx});
            assign w_vy[i] = $signed({w_ty[SIGFIG-1], w_ty})
                           - $signed({w_sy[SIGFIG-1], w_sy});
        end

        // Cross products are kept exact; widths cover the extra subtract bit.
        for (genvar i = 0; i < VERTS; i++) begin : g_edge
            localparam int J = (i + 1) % VERTS;
            assign w_d[i] = DW'(w_vx[i]) * DW'(w_vy[J])
                          - DW'(w_vx[J]) * DW'(w_vy[i]);
            assign w_neg[i]  = w_d[i][DW-1];
            assign w_zero[i] = (w_d[i] == '0);
        end

        assign w_in_neg = (w_neg[0] | w_zero[0]) & w_neg[1]
                        & (w_neg[2] | w_zero[2]);
        assign w_in_pos = ~w_neg[0] & ~w_neg[1] & ~w_zero[1] & ~w_neg[2];
        assign w_mask[s] = validSamp_R16H[s]
                         & (w_in_neg | (cull_mode_R16H & w_in_pos));

        assign w_hit[(0*SAMPS+s)*SIGFIG +: SIGFIG] = w_sx;
        assign w_hit[(1*SAMPS+s)*SIGFIG +: SIGFIG] = w_sy;
        for (genvar a = 2; a < AXIS; a++) begin : g_z
            assign w_hit[(a*SAMPS+s)*SIGFIG +: SIGFIG] =
                tri_R16S[a*SIGFIG +: SIGFIG];
        end
    end

    logic [PIPE_DEPTH-1:0] r_vld;
    logic [SAMPS-1:0]      r_msk [PIPE_DEPTH];
    logic [HW-1:0]         r_hit [PIPE_DEPTH];
    logic [OW-1:0]         r_col [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] w_load;
    logic [PIPE_DEPTH-1:0] w_nv;
    logic [SAMPS-1:0]      w_nm  [PIPE_DEPTH];
    logic [HW-1:0]         w_nh  [PIPE_DEPTH];
    logic [OW-1:0]         w_nc  [PIPE_DEPTH];

    // A stage loads when it is empty or its content moves on downstream.
    always_comb begin
        w_load = '0;
        w_load[PIPE_DEPTH-1] = ~r_vld[PIPE_DEPTH-1] | out_ready;
        for (int k = PIPE_DEPTH - 2; k >= 0; k--) begin
            w_load[k] = ~r_vld[k] | w_load[k+1];
        end
    end

    always_comb begin
        w_nv    = '0;
        w_nv[0] = in_valid;
        w_nm[0] = w_mask;
        w_nh[0] = w_hit;
        w_nc[0] = color_R16U;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            w_nv[k] = r_vld[k-1];
            w_nm[k] = r_msk[k-1];
            w_nh[k] = r_hit[k-1];
            w_nc[k] = r_col[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_msk[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                if (w_load[k]) begin
                    r_vld[k] <= w_nv[k];
                    r_msk[k] <= w_nm[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (w_load[k]) begin
                r_hit[k] <= w_nh[k];
                r_col[k] <= w_nc[k];
            end
        end
    end

    assign in_ready       = w_load[0];
    assign out_valid      = r_vld[PIPE_DEPTH-1];
    assign hit_valid_R18H = r_msk[PIPE_DEPTH-1];
    assign hit_R18S       = r_hit[PIPE_DEPTH-1];
    assign color_R18U     = r_col[PIPE_DEPTH-1];

`ifdef SAMPLETEST_STATS_EN
    localparam int PW = $clog2(SAMPS + 1);

    logic [31:0]   r_stat;
    logic [PW-1:0] w_pop;
    logic [32:0]   w_sum;

    always_comb begin
        w_pop = '0;
        for (int s = 0; s < SAMPS; s++) begin
            w_pop = w_pop + PW'(hit_valid_R18H[s]);
        end
    end

    assign w_sum = {1'b0, r_stat} + 33'(w_pop);

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_stat <= '0;
        end else if (out_valid && out_ready) begin
            r_stat <= w_sum[32] ? '1 : w_sum[31:0];
        end
    end

    assign stat_hits = r_stat;
`endif

endmodule

// File: tb/tb_sampletest_stream.sv
// Scoreboard bench for sampletest_stream: directed edge cases, stalled burst,
// mid-flight reset and (with SAMPLETEST_STATS_EN) the hit counter.
`timescale 1ns/1ps
module tb_sampletest_stream;

    localparam int SIGFIG     = 24;
    localparam int VERTS      = 3;
    localparam int AXIS       = 3;
    localparam int COLORS     = 3;
    localparam int SAMPS      = 4;
    localparam int PIPE_DEPTH = 2;
    localparam int HW  = AXIS * SAMPS * SIGFIG;
    localparam int CLW = COLORS * SIGFIG;

    typedef struct packed {
        logic [2:0][23:0] tx;
        logic [2:0][23:0] ty;
        logic [2:0][23:0] tz;
        logic [3:0][23:0] sx;
        logic [3:0][23:0] sy;
        logic [3:0]       vs;
        logic             mode;
        logic [2:0][23:0] col;
        logic             use_h;
        logic [3:0]       hmask;
        logic             lat;
    } txn_t;

    typedef struct packed {
        logic [3:0]     m;
        logic [HW-1:0]  hit;
        logic [CLW-1:0] col;
        int             acc;
        logic           lat;
    } exp_t;

    logic                         clk;
    logic                         rst;
    logic [VERTS*AXIS*SIGFIG-1:0] tri_R16S;
    logic [CLW-1:0]               color_R16U;
    logic [2*SAMPS*SIGFIG-1:0]    sample_R16S;
    logic [SAMPS-1:0]             validSamp_R16H;
    logic                         cull_mode_R16H;
    logic                         in_valid;
    logic                         in_ready;
    logic [HW-1:0]                hit_R18S;
    logic [CLW-1:0]               color_R18U;
    logic [SAMPS-1:0]             hit_valid_R18H;
    logic                         out_valid;
    logic                         out_ready;
`ifdef SAMPLETEST_STATS_EN
    logic                         stat_clr;
    logic [31:0]                  stat_hits;
`endif

    sampletest_stream #(
        .SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS),
        .COLORS(COLORS), .SAMPS(SAMPS), .PIPE_DEPTH(PIPE_DEPTH)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .tri_R16S(tri_R16S),
        .color_R16U(color_R16U),
        .sample_R16S(sample_R16S),
        .validSamp_R16H(validSamp_R16H),
        .cull_mode_R16H(cull_mode_R16H),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .hit_R18S(hit_R18S),
        .color_R18U(color_R18U),
        .hit_valid_R18H(hit_valid_R18H),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef SAMPLETEST_STATS_EN
        ,
        .stat_clr(stat_clr),
        .stat_hits(stat_hits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    txn_t cur;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_blk = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [3:0] model(input txn_t t);
        longint x[3];
        longint y[3];
        longint d[3];
        logic [3:0] m;
        m = '0;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 3; i++) begin
                x[i] = longint'($signed(t.tx[i])) - longint'($signed(t.sx[s]));
                y[i] = longint'($signed(t.ty[i])) - longint'($signed(t.sy[s]));
            end
            for (int i = 0; i < 3; i++) begin
                d[i] = x[i] * y[(i+1)%3] - x[(i+1)%3] * y[i];
            end
            m[s] = t.vs[s] &&
                   ((d[0] <= 0 && d[1] < 0 && d[2] <= 0) ||
                    (t.mode && d[0] >= 0 && d[1] > 0 && d[2] >= 0));
        end
        return m;
    endfunction

    function automatic exp_t expect_of(input txn_t t);
        exp_t e;
        e = '0;
        e.m = t.use_h ? t.hmask : model(t);
        for (int s = 0; s < 4; s++) begin
            e.hit[s*24 +: 24]     = t.sx[s];
            e.hit[(4+s)*24 +: 24] = t.sy[s];
            e.hit[(8+s)*24 +: 24] = t.tz[0];
        end
        e.col = t.col;
        e.lat = t.lat;
        return e;
    endfunction

    function automatic txn_t with_tri(input txn_t t, input int x0, y0,
                                      x1, y1, x2, y2);
        t.tx[0] = 24'(x0); t.ty[0] = 24'(y0);
        t.tx[1] = 24'(x1); t.ty[1] = 24'(y1);
        t.tx[2] = 24'(x2); t.ty[2] = 24'(y2);
        return t;
    endfunction

    function automatic txn_t with_samp(input txn_t t, input int a0, b0,
                                       a1, b1, a2, b2, a3, b3);
        t.sx[0] = 24'(a0); t.sy[0] = 24'(b0);
        t.sx[1] = 24'(a1); t.sy[1] = 24'(b1);
        t.sx[2] = 24'(a2); t.sy[2] = 24'(b2);
        t.sx[3] = 24'(a3); t.sy[3] = 24'(b3);
        return t;
    endfunction

    function automatic txn_t rnd(input bit big);
        txn_t t;
        logic [31:0] r;
        t = '0;
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            t.tx[i] = big ? r[23:0] : 24'(int'($urandom_range(0, 40)) - 20);
            r = $urandom;
            t.ty[i] = big ? r[23:0] : 24'(int'($urandom_range(0, 40)) - 20);
            r = $urandom;
            t.tz[i] = r[23:0];
            r = $urandom;
            t.col[i] = r[23:0];
        end
        for (int s = 0; s < 4; s++) begin
            r = $urandom;
            t.sx[s] = big ? r[23:0] : 24'(int'($urandom_range(0, 30)) - 15);
            r = $urandom;
            t.sy[s] = big ? r[23:0] : 24'(int'($urandom_range(0, 30)) - 15);
        end
        r = $urandom;
        t.vs   = r[3:0];
        t.mode = r[4];
        return t;
    endfunction

    task automatic apply(input txn_t t);
        for (int i = 0; i < 3; i++) begin
            tri_R16S[(i*3+0)*24 +: 24] = t.tx[i];
            tri_R16S[(i*3+1)*24 +: 24] = t.ty[i];
            tri_R16S[(i*3+2)*24 +: 24] = t.tz[i];
        end
        for (int s = 0; s < 4; s++) begin
            sample_R16S[s*24 +: 24]     = t.sx[s];
            sample_R16S[(4+s)*24 +: 24] = t.sy[s];
        end
        color_R16U     = t.col;
        validSamp_R16H = t.vs;
        cull_mode_R16H = t.mode;
    endtask

    task automatic send(input txn_t t);
        int  n;
        logic acc;
        cur = t;
        apply(t);
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        chk("send_accept", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
        end else if (chk_en) begin
            chk("in_ready", in_ready, (q.size() < PIPE_DEPTH) || out_ready);
            if (!in_ready) n_blk++;
            if (q.size() == 0) begin
                chk("no_spurious_out", out_valid, 0);
            end else if (out_valid) begin
                chk("mask", hit_valid_R18H, q[0].m);
                chk("hit", hit_R18S, q[0].hit);
                chk("color", color_R18U, q[0].col);
                if (out_ready) begin
                    if (q[0].lat) chk("latency", cyc - q[0].acc, PIPE_DEPTH);
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                e = expect_of(cur);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        txn_t fwd;
        int   n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tri_R16S = '0; color_R16U = '0; sample_R16S = '0;
        validSamp_R16H = '0; cull_mode_R16H = 1'b0;
`ifdef SAMPLETEST_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mask", hit_valid_R18H, 0);
        chk("rst_in_ready", in_ready, 1);
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        fwd = '0;
        fwd.tz  = {24'd7, 24'hFFFFFB, 24'hFFFED4};
        fwd.col = {24'h000FFF, 24'hABCDEF, 24'h123456};
        fwd = with_tri(fwd, 0, 0, 0, 8, 8, 0);
        fwd = with_samp(fwd, 1, 1, 7, 7, 0, 4, 9, 0);
        fwd.vs = 4'hF;
        fwd.use_h = 1'b1;
        fwd.lat = 1'b1;

        t = fwd; t.mode = 1'b0; t.hmask = 4'b0101;
        send(t); drain();
        t = fwd; t.mode = 1'b1; t.hmask = 4'b0101;
        send(t); drain();
        t = with_tri(fwd, 8, 0, 0, 8, 0, 0); t.mode = 1'b0; t.hmask = 4'b0000;
        send(t); drain();
        t = with_tri(fwd, 8, 0, 0, 8, 0, 0); t.mode = 1'b1; t.hmask = 4'b0001;
        send(t); drain();
        t = with_tri(fwd, 0, 0, 4, 4, 8, 8);
        t = with_samp(t, 4, 4, 4, 4, 4, 4, 4, 4);
        t.mode = 1'b1; t.hmask = 4'b0000;
        send(t); drain();
        t = fwd; t.vs = 4'b0000; t.hmask = 4'b0000;
        send(t); drain();
        t = fwd; t.vs = 4'b0100; t.hmask = 4'b0100;
        send(t); drain();

        n_blk = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rnd(i >= 4));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("in_ready_drop", n_blk > 0, 1);

        for (int i = 0; i < 12; i++) send(rnd(i[0]));
        drain();

        out_ready = 1'b0;
        send(rnd(1'b0));
        send(rnd(1'b0));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_flush_valid", out_valid, 0);
        chk("rst_flush_mask", hit_valid_R18H, 0);
        repeat (6) @(posedge clk);
        #1;

`ifdef SAMPLETEST_STATS_EN
        stat_clr = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        @(negedge clk);
        chk("stat_clr_idle", stat_hits, 0);
        @(posedge clk);
        #1;
        t = with_samp(fwd, 1, 1, 2, 2, 1, 3, 3, 1);
        t.lat = 1'b0; t.hmask = 4'b1111;
        send(t);
        t.vs = 4'b0000; t.hmask = 4'b0000;
        send(t);
        t = fwd; t.lat = 1'b0; t.hmask = 4'b0101;
        send(t);
        drain();
        chk("stat_sum", stat_hits, 6);
        out_ready = 1'b0;
        send(t);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("stat_wait", out_valid, 1);
        @(posedge clk);
        #1 stat_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        @(negedge clk);
        chk("stat_clr_prio", stat_hits, 0);
        drain();
`endif

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
